// File: rtl/card_dealer.sv
// Card dealer: random draw from a 52-card deck with linear-scan fallback after RETRY_MAX rejects.
// Define DEALER_INFINITE_DECK_EN to build an infinite deck (no bitmap, no SCAN state).
module card_dealer #(
    parameter int unsigned RETRY_MAX = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] rand_in,
    input  logic        deal_req,
    input  logic        shuffle,
    output logic        card_valid,
    output logic [1:0]  card_suit,
    output logic [3:0]  card_rank,
    output logic [3:0]  card_points,
    output logic [5:0]  cards_left,
    output logic        deck_empty,
    output logic        busy,
    output logic        empty_err
);
    localparam int unsigned RW = $clog2(RETRY_MAX + 1);

`ifdef DEALER_INFINITE_DECK_EN
    typedef enum logic [1:0] {IDLE, DRAW} state_t;
`else
    typedef enum logic [1:0] {IDLE, DRAW, SCAN} state_t;
`endif

    state_t        state, next_state;
    logic [RW-1:0] retry_cnt;
    logic [5:0]    draw_idx, sel_idx, rem;
    logic          draw_ok, accept, reject, to_scan, err_set;
    logic [1:0]    dec_suit;
    logic [3:0]    dec_rank, dec_points;
    logic [25:0]   unused_rand_bits;

    assign draw_idx         = rand_in[5:0];
    assign unused_rand_bits = rand_in[31:6];
    assign busy             = (state != IDLE);

`ifdef DEALER_INFINITE_DECK_EN
    assign draw_ok    = (draw_idx < 6'd52);
    assign cards_left = 6'd52;
    assign deck_empty = 1'b0;
`else
    logic [51:0] used;
    logic [63:0] used_ext;
    logic [5:0]  scan_ptr;
    logic [5:0]  left_q;

    // Out-of-range indices read as "used" so a single lookup covers both reject causes
    assign used_ext   = {12'hFFF, used};
    assign draw_ok    = !used_ext[draw_idx];
    assign cards_left = left_q;
    assign deck_empty = (left_q == 6'd0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        reject     = 1'b0;
        to_scan    = 1'b0;
        err_set    = 1'b0;
        sel_idx    = draw_idx;
        case (state)
            IDLE: begin
                if (deal_req) begin
                    if (deck_empty) begin
                        err_set = 1'b1;
                    end else begin
                        next_state = DRAW;
                    end
                end
            end
            DRAW: begin
                if (draw_ok) begin
                    accept     = 1'b1;
                    next_state = IDLE;
                end else if (retry_cnt == RW'(RETRY_MAX - 1)) begin
`ifdef DEALER_INFINITE_DECK_EN
                    // Any index below 32 is valid with replacement, so fold the draw
                    accept     = 1'b1;
                    sel_idx    = {1'b0, draw_idx[4:0]};
                    next_state = IDLE;
`else
                    to_scan    = 1'b1;
                    next_state = SCAN;
`endif
                end else begin
                    reject = 1'b1;
                end
            end
`ifndef DEALER_INFINITE_DECK_EN
            SCAN: begin
                sel_idx = scan_ptr;
                if (!used_ext[scan_ptr]) begin
                    accept     = 1'b1;
                    next_state = IDLE;
                end
            end
`endif
            default: next_state = IDLE;
        endcase
        if (shuffle) begin
            next_state = IDLE;
            accept     = 1'b0;
            reject     = 1'b0;
            to_scan    = 1'b0;
            err_set    = 1'b0;
        end
    end

    // Index -> suit/rank by subtracting whole suits instead of dividing by 13
    always_comb begin
        dec_suit = 2'd0;
        rem      = sel_idx;
        if (sel_idx >= 6'd39) begin
            dec_suit = 2'd3;
            rem      = sel_idx - 6'd39;
        end else if (sel_idx >= 6'd26) begin
            dec_suit = 2'd2;
            rem      = sel_idx - 6'd26;
        end else if (sel_idx >= 6'd13) begin
            dec_suit = 2'd1;
            rem      = sel_idx - 6'd13;
        end
        dec_rank = 4'(rem + 6'd1);
        if (dec_rank == 4'd1) begin
            dec_points = 4'd11;
        end else if (dec_rank > 4'd10) begin
            dec_points = 4'd10;
        end else begin
            dec_points = dec_rank;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retry_cnt   <= '0;
            card_valid  <= 1'b0;
            empty_err   <= 1'b0;
            card_suit   <= '0;
            card_rank   <= '0;
            card_points <= '0;
`ifndef DEALER_INFINITE_DECK_EN
            used        <= '0;
            left_q      <= 6'd52;
            scan_ptr    <= '0;
`endif
        end else begin
            card_valid <= accept;
            empty_err  <= err_set;
            if (accept) begin
                card_suit   <= dec_suit;
                card_rank   <= dec_rank;
                card_points <= dec_points;
            end
            if (shuffle || accept || to_scan) begin
                retry_cnt <= '0;
            end else if (reject) begin
                retry_cnt <= retry_cnt + RW'(1);
            end
`ifndef DEALER_INFINITE_DECK_EN
            if (shuffle) begin
                used     <= '0;
                left_q   <= 6'd52;
                scan_ptr <= '0;
            end else begin
                if (accept) begin
                    used   <= used | (52'd1 << sel_idx);
                    left_q <= left_q - 6'd1;
                end
                if (to_scan) begin
                    scan_ptr <= (draw_idx < 6'd52) ? draw_idx : 6'd0;
                end else if (state == SCAN && !accept) begin
                    scan_ptr <= (scan_ptr == 6'd51) ? 6'd0 : scan_ptr + 6'd1;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_card_dealer.sv
// Directed self-checking bench for card_dealer (default without-replacement build).
module tb_card_dealer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rand_in;
    logic        deal_req;
    logic        shuffle;
    logic        card_valid;
    logic [1:0]  card_suit;
    logic [3:0]  card_rank;
    logic [3:0]  card_points;
    logic [5:0]  cards_left;
    logic        deck_empty;
    logic        busy;
    logic        empty_err;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    card_dealer #(.RETRY_MAX(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rand_in     (rand_in),
        .deal_req    (deal_req),
        .shuffle     (shuffle),
        .card_valid  (card_valid),
        .card_suit   (card_suit),
        .card_rank   (card_rank),
        .card_points (card_points),
        .cards_left  (cards_left),
        .deck_empty  (deck_empty),
        .busy        (busy),
        .empty_err   (empty_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Latency counts cycles from the cycle deal_req is driven to the cycle card_valid is seen
    task automatic deal(input int limit, output int lat);
        deal_req = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
            deal_req = 1'b0;
        end while (card_valid !== 1'b1 && lat < limit);
    endtask

    function automatic int exp_pts(input int rank);
        if (rank == 1) return 11;
        if (rank >= 10) return 10;
        return rank;
    endfunction

    typedef struct { int idx; int suit; int rank; int pts; } vec_t;
    vec_t vecs[8] = '{
        '{12, 0, 13, 10}, '{13, 1, 1, 11}, '{51, 3, 13, 10}, '{26, 2, 1, 11},
        '{10, 0, 11, 10}, '{9, 0, 10, 10}, '{1, 0, 2, 2},    '{25, 1, 13, 10}
    };

    initial begin
        int lat;
        int idx;
        int dup;
        int bad;
        int timeouts;
        logic [51:0] seen;

        rst_n = 1'b0; rand_in = 32'h0; deal_req = 1'b0; shuffle = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        check("rst_valid", card_valid, 0);
        check("rst_suit", card_suit, 0);
        check("rst_rank", card_rank, 0);
        check("rst_points", card_points, 0);
        check("rst_err", empty_err, 0);
        check("rst_busy", busy, 0);
        check("rst_empty", deck_empty, 0);
        check("rst_left", cards_left, 52);

        // Index 0 on the first try
        deal(10, lat);
        check("d0_lat", lat, 2);
        check("d0_valid", card_valid, 1);
        check("d0_suit", card_suit, 0);
        check("d0_rank", card_rank, 1);
        check("d0_points", card_points, 11);
        check("d0_left", cards_left, 51);
        tick();
        check("d0_pulse", card_valid, 0);

        rand_in = 32'h25;
        deal(10, lat);
        check("d37_lat", lat, 2);
        check("d37_suit", card_suit, 2);
        check("d37_rank", card_rank, 12);
        check("d37_points", card_points, 10);
        tick();
        check("hold_rank", card_rank, 12);

        // 37 now used: 16 rejects, SCAN 37 (used), 38 dealt
        deal(40, lat);
        check("scan38_lat", lat, 19);
        check("scan38_valid", card_valid, 1);
        check("scan38_suit", card_suit, 2);
        check("scan38_rank", card_rank, 13);
        check("scan38_points", card_points, 10);
        check("scan38_left", cards_left, 49);
        tick();

        shuffle = 1'b1; tick(); shuffle = 1'b0;
        check("shuf_left", cards_left, 52);
        check("shuf_busy", busy, 0);

        rand_in = 32'h3F;
        deal(40, lat);
        check("d63_lat", lat, 18);
        check("d63_suit", card_suit, 0);
        check("d63_rank", card_rank, 1);
        check("d63_points", card_points, 11);
        tick();

        foreach (vecs[i]) begin
            rand_in = 32'(vecs[i].idx);
            deal(10, lat);
            check($sformatf("vec%0d_lat", vecs[i].idx), lat, 2);
            check($sformatf("vec%0d_suit", vecs[i].idx), card_suit, 32'(vecs[i].suit));
            check($sformatf("vec%0d_rank", vecs[i].idx), card_rank, 32'(vecs[i].rank));
            check($sformatf("vec%0d_points", vecs[i].idx), card_points, 32'(vecs[i].pts));
            tick();
        end
        check("vec_left", cards_left, 43);

        // Shuffle while in SCAN
        rand_in = 32'h3F;
        deal_req = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
            deal_req = 1'b0;
        end
        check("scan_busy", busy, 1);
        shuffle = 1'b1; tick(); shuffle = 1'b0;
        check("abort_valid", card_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_left", cards_left, 52);
        tick();
        check("abort_valid2", card_valid, 0);
        rand_in = 32'h0;
        deal(10, lat);
        check("clear_lat", lat, 2);
        check("clear_rank", card_rank, 1);
        tick();

        // shuffle beats deal_req in the same cycle
        shuffle = 1'b1; deal_req = 1'b1;
        tick();
        shuffle = 1'b0; deal_req = 1'b0;
        check("both_busy", busy, 0);
        check("both_valid", card_valid, 0);
        tick();
        check("both_valid2", card_valid, 0);
        rand_in = 32'h5;
        deal(10, lat);
        check("after_lat", lat, 2);
        check("after_rank", card_rank, 6);
        check("after_points", card_points, 6);
        check("after_left", cards_left, 51);
        tick();

        // Full deck with random draws
        shuffle = 1'b1; tick(); shuffle = 1'b0;
        seen = '0; dup = 0; bad = 0; timeouts = 0;
        for (int k = 0; k < 52; k++) begin
            rand_in = $urandom;
            deal(100, lat);
            if (card_valid !== 1'b1) begin
                timeouts++;
            end else begin
                idx = int'(card_suit) * 13 + int'(card_rank) - 1;
                if (card_rank < 4'd1 || card_rank > 4'd13 || seen[idx]) dup++;
                else seen[idx] = 1'b1;
                if (int'(card_points) != exp_pts(int'(card_rank))) bad++;
            end
            tick();
        end
        check("full_timeouts", timeouts, 0);
        check("full_dups", dup, 0);
        check("full_points", bad, 0);
        check("full_seen", $countones(seen), 52);
        check("full_left", cards_left, 0);
        check("full_empty", deck_empty, 1);

        deal_req = 1'b1; tick(); deal_req = 1'b0;
        check("empty_err", empty_err, 1);
        check("empty_valid", card_valid, 0);
        check("empty_busy", busy, 0);
        tick();
        check("empty_err_pulse", empty_err, 0);
        check("empty_valid2", card_valid, 0);

        // Reset aborts an in-flight deal
        shuffle = 1'b1; tick(); shuffle = 1'b0;
        rand_in = 32'h3F;
        deal_req = 1'b1; tick(); deal_req = 1'b0;
        tick(); tick();
        rst_n = 1'b0; shuffle = 1'b1; tick();
        rst_n = 1'b1; shuffle = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", card_valid, 0);
        check("mid_rst_left", cards_left, 52);
        check("mid_rst_rank", card_rank, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (card_valid !== 1'b0) break;
        end
        check("mid_rst_novalid", card_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
